ts_ser2par_rx: RTL
==================

// Module: ts_ser2par_rx
// PURPOSE
//   Serial MPEG-TS receiver: deserialises the 1-bit LSB-first TS stream (sync/valid/data)
//   into 188-byte parallel packets with sop/eop framing. Checks sync byte, packet length
//   and continuity counter. Sits at the TS input of the scrambler/IPQAM datapath.
// PARAMETERS
//   U_DLY        1     register assignment delay (simulation only)
//   PKT_LEN      188   bytes per TS packet
//   TIMEOUT      4096  clk cycles without ts_valid_ser in RECV before the packet is aborted
//   CC_CHECK_EN  1     1 = enable continuity-counter check, 0 = err_cc tied low
// PORTS
//   clk           in   1   system clock; serial inputs are synchronous to it
//   rst_n         in   1   asynchronous active-low reset
//   ts_sync_ser   in   1   one-cycle pulse coincident with bit0 of the 0x47 byte
//   ts_valid_ser  in   1   qualifies ts_data_ser; one bit per valid cycle
//   ts_data_ser   in   1   serial data, LSB first
//   ts_valid      out  1   parallel byte strobe
//   ts_data       out  8   parallel byte (valid only when ts_valid=1, else 8'h00)
//   ts_sop        out  1   with ts_valid on byte 1 of a packet
//   ts_eop        out  1   with ts_valid on byte PKT_LEN of a packet
//   err_sync      out  1   pulse with ts_sop when byte 1 != 8'h47
//   err_len       out  1   pulse: packet aborted (early re-sync or timeout)
//   err_cc        out  1   pulse with byte 4 output on continuity error
//   pkt_cnt       out  16  count of packets completed with ts_eop; wraps 16'hFFFF -> 0
// BEHAVIOUR
//   Reset: all outputs 0; FSM=HUNT; shift reg, bit_cnt, byte_cnt, cc_ref, cc_vld, timer = 0.
//   FSM HUNT: ignore valid bits until ts_sync_ser & ts_valid_ser -> RECV; that bit is bit0.
//     ts_sync_ser without ts_valid_ser is ignored in every state.
//   FSM RECV: each valid cycle: shift <= {ts_data_ser, shift[7:1]}, bit_cnt++ (3-bit wrap).
//     Gaps in ts_valid_ser are allowed anywhere (bits accumulate across gaps).
//     8th bit (bit_cnt==7 & valid): next cycle ts_valid=1, ts_data={ts_data_ser,shift[7:1]};
//     latency = 1 clk after the last bit. byte_cnt++ (1..PKT_LEN).
//     byte_cnt==1: ts_sop=1; err_sync=1 if byte!=8'h47 (packet still forwarded).
//     byte_cnt==PKT_LEN: ts_eop=1, pkt_cnt++, -> HUNT (same-cycle sync on next bit accepted:
//       a sync&valid in the cycle after the last bit starts the next packet with no gap).
//   Early re-sync: sync&valid in RECV with (bit_cnt!=0 or byte_cnt!=0) -> err_len pulse
//     next clk, partial packet dropped (no ts_eop), new packet starts with this bit as bit0.
//   Timeout: timer counts clk cycles with ts_valid_ser=0 in RECV, cleared on valid;
//     timer==TIMEOUT-1 -> err_len pulse, -> HUNT, no ts_eop, counters cleared.
//   CC check (CC_CHECK_EN=1): byte 4 [3:0]=cc, [4]=payload flag (adaptation_field_ctrl[0]).
//     If cc_vld & payload & cc != cc_ref+1 (4-bit wrap, F->0 legal) -> err_cc with byte 4.
//     If payload=0, expect cc == cc_ref (no error on repeat). Then cc_ref<=cc, cc_vld<=1.
//     First packet after reset: no check. Aborted packet does not update cc_ref.
//   Simultaneous: byte completion and early re-sync in same cycle cannot occur (re-sync bit
//     is bit0); err_sync and err_cc never coincide (bytes 1 and 4).
//   Reset mid-packet: immediate return to reset state; no eop/err pulses emitted.
//   All outputs registered; all pulses exactly one clk wide.
// TESTING
//   1 Generator (PKT_INTERVAL=4500, payload ctrl 2'b01), 4 packets -> 4x188 ts_valid,
//     byte1=8'h47, byte2=8'h00, byte3=8'h14, byte n>=5 = n-4, pkt_cnt=4, no errors.
//   2 Back-to-back packets, random 0-3 cycle valid gaps inside bytes -> identical bytes,
//     latency 1 clk after each 8th bit, sop/eop on bytes 1/188.
//   3 Sync pulse after byte 100, bit 3 -> err_len one pulse, no eop, next packet received
//     intact, pkt_cnt increments only for it.
//   4 Byte1=8'hB8, later CC sequence E,F,0,2 -> err_sync with sop of bad packet;
//     F->0 no error; 0->2 err_cc with byte 4 of last packet.
//   5 Valid stops after byte 50 for TIMEOUT cycles -> err_len at cycle TIMEOUT, FSM HUNT,
//     following packet decodes cleanly; rst_n low mid-packet -> all outputs 0 at once.

Source files
------------

// File: rtl/ts_ser2par_rx.sv
// -----------------------------------------------------------------------------
// ts_ser2par_rx
// Serial MPEG-TS receiver. Deserialises a 1-bit, LSB-first TS stream into
// parallel bytes with packet framing. It checks the sync byte, the packet
// length (early re-sync or timeout) and the continuity counter.
//
// Ports
//   clk           in   system clock; serial inputs are synchronous to it
//   rst_n         in   asynchronous active-low reset
//   ts_sync_ser   in   pulse coincident with bit0 of the 0x47 byte
//   ts_valid_ser  in   qualifies ts_data_ser, one bit per valid cycle
//   ts_data_ser   in   serial data, LSB first
//   ts_valid      out  parallel byte strobe
//   ts_data       out  parallel byte (8'h00 when ts_valid=0)
//   ts_sop        out  with ts_valid on byte 1 of a packet
//   ts_eop        out  with ts_valid on byte PKT_LEN of a packet
//   err_sync      out  with ts_sop when byte 1 != 8'h47
//   err_len       out  packet aborted (early re-sync or timeout)
//   err_cc        out  with byte 4 on a continuity-counter error
//   pkt_cnt       out  packets completed with ts_eop (wrapping)
// -----------------------------------------------------------------------------
module ts_ser2par_rx #(
   parameter int PKT_LEN     = 188,
   parameter int TIMEOUT     = 4096,
   parameter int CC_CHECK_EN = 1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ts_sync_ser,
   input  logic        ts_valid_ser,
   input  logic        ts_data_ser,
   output logic        ts_valid,
   output logic [7:0]  ts_data,
   output logic        ts_sop,
   output logic        ts_eop,
   output logic        err_sync,
   output logic        err_len,
   output logic        err_cc,
   output logic [15:0] pkt_cnt
);

   localparam int BW = $clog2(PKT_LEN + 1);
   localparam int TW = $clog2(TIMEOUT);
   localparam logic [BW-1:0] LAST_BYTE = BW'(PKT_LEN - 1);
   localparam logic [BW-1:0] CC_BYTE   = BW'(3);
   localparam logic [TW-1:0] TIMER_MAX = TW'(TIMEOUT - 1);

   typedef enum logic {HUNT, RECV} state_t;

   state_t        state_q;
   logic [7:0]    shift_q;
   logic [2:0]    bit_cnt_q;
   logic [BW-1:0] byte_cnt_q;
   logic [TW-1:0] timer_q;
   logic [3:0]    cc_ref_q;
   logic [3:0]    cc_pend_q;
   logic          cc_vld_q;

   logic          ts_valid_q;
   logic [7:0]    ts_data_q;
   logic          ts_sop_q;
   logic          ts_eop_q;
   logic          err_sync_q;
   logic          err_len_q;
   logic          err_cc_q;
   logic [15:0]   pkt_cnt_q;

   logic [7:0]    byte_d;
   logic          sync_bit_d;
   logic [3:0]    cc_exp_d;
   logic          cc_bad_d;

   // Byte as it will look once the current bit is shifted in (LSB first).
   assign byte_d     = {ts_data_ser, shift_q[7:1]};
   assign sync_bit_d = ts_sync_ser & ts_valid_ser;
   // A payload-carrying packet must advance the counter; a packet without
   // payload must repeat it.
   assign cc_exp_d   = byte_d[4] ? (cc_ref_q + 4'd1) : cc_ref_q;
   assign cc_bad_d   = (CC_CHECK_EN != 0) && cc_vld_q && (byte_d[3:0] != cc_exp_d);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= HUNT;
         shift_q    <= '0;
         bit_cnt_q  <= '0;
         byte_cnt_q <= '0;
         timer_q    <= '0;
         cc_ref_q   <= '0;
         cc_pend_q  <= '0;
         cc_vld_q   <= 1'b0;
         ts_valid_q <= 1'b0;
         ts_data_q  <= '0;
         ts_sop_q   <= 1'b0;
         ts_eop_q   <= 1'b0;
         err_sync_q <= 1'b0;
         err_len_q  <= 1'b0;
         err_cc_q   <= 1'b0;
         pkt_cnt_q  <= '0;
      end else begin
         // All strobes are single-cycle pulses.
         ts_valid_q <= 1'b0;
         ts_data_q  <= '0;
         ts_sop_q   <= 1'b0;
         ts_eop_q   <= 1'b0;
         err_sync_q <= 1'b0;
         err_len_q  <= 1'b0;
         err_cc_q   <= 1'b0;

         case (state_q)
            HUNT: begin
               if (sync_bit_d) begin
                  state_q    <= RECV;
                  shift_q    <= byte_d;
                  bit_cnt_q  <= 3'd1;
                  byte_cnt_q <= '0;
                  timer_q    <= '0;
               end
            end

            RECV: begin
               if (sync_bit_d && (bit_cnt_q != 3'd0 || byte_cnt_q != '0)) begin
                  // Early re-sync: drop the partial packet, this bit is bit0
                  // of the new one. The pending CC value is never committed.
                  err_len_q  <= 1'b1;
                  shift_q    <= byte_d;
                  bit_cnt_q  <= 3'd1;
                  byte_cnt_q <= '0;
                  timer_q    <= '0;
               end else if (ts_valid_ser) begin
                  timer_q   <= '0;
                  shift_q   <= byte_d;
                  bit_cnt_q <= bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     ts_valid_q <= 1'b1;
                     ts_data_q  <= byte_d;
                     byte_cnt_q <= byte_cnt_q + BW'(1);
                     if (byte_cnt_q == '0) begin
                        ts_sop_q   <= 1'b1;
                        err_sync_q <= (byte_d != 8'h47);
                     end
                     if (byte_cnt_q == CC_BYTE) begin
                        cc_pend_q <= byte_d[3:0];
                        err_cc_q  <= cc_bad_d;
                     end
                     if (byte_cnt_q == LAST_BYTE) begin
                        // Only a complete packet updates the CC reference.
                        ts_eop_q   <= 1'b1;
                        pkt_cnt_q  <= pkt_cnt_q + 16'd1;
                        state_q    <= HUNT;
                        bit_cnt_q  <= '0;
                        byte_cnt_q <= '0;
                        if (CC_CHECK_EN != 0) begin
                           cc_ref_q <= cc_pend_q;
                           cc_vld_q <= 1'b1;
                        end
                     end
                  end
               end else if (timer_q == TIMER_MAX) begin
                  err_len_q  <= 1'b1;
                  state_q    <= HUNT;
                  bit_cnt_q  <= '0;
                  byte_cnt_q <= '0;
                  timer_q    <= '0;
               end else begin
                  timer_q <= timer_q + TW'(1);
               end
            end

            default: state_q <= HUNT;
         endcase
      end
   end

   assign ts_valid = ts_valid_q;
   assign ts_data  = ts_data_q;
   assign ts_sop   = ts_sop_q;
   assign ts_eop   = ts_eop_q;
   assign err_sync = err_sync_q;
   assign err_len  = err_len_q;
   assign err_cc   = err_cc_q;
   assign pkt_cnt  = pkt_cnt_q;

endmodule
